// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared loader state encoding and default memory map constants
package instr_loader_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        LOAD  = 3'd3,
        WRITE = 3'd4,
        FIN   = 3'd5
    } state_t;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0040_0000;
    localparam int          DEF_DEPTH_WORDS = 256;
endpackage

// File: rtl/instr_loader.sv
// instr_loader: streams a length-prefixed big-endian byte image into instruction memory
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);
    localparam logic [16:0] DEPTH = 17'(DEPTH_WORDS);
    state_t      state, nxt;
    logic [15:0] n_words;
    logic [15:0] hdr;
    logic [23:0] shreg;
    logic [1:0]  idx;
    logic        acc;
    logic        too_big;
    assign acc     = rx_valid && rx_ready;
    assign hdr     = {n_words[15:8], rx_data};
    assign too_big = {1'b0, hdr} > DEPTH;
    always_comb begin
        nxt      = state;
        rx_ready = state == HDR0 || state == HDR1 || state == LOAD;
        mem_we   = state == WRITE;
        cpu_hold = state != IDLE;
        done     = state == FIN;
        case (state)
            IDLE:    nxt = start ? HDR0 : IDLE;
            HDR0:    nxt = acc ? HDR1 : HDR0;
            HDR1:    nxt = !acc ? HDR1 : hdr == 16'd0 ? FIN : too_big ? IDLE : LOAD;
            LOAD:    nxt = (acc && idx == 2'd3) ? WRITE : LOAD;
            WRITE:   nxt = (words_loaded + 16'd1 == n_words) ? FIN : LOAD;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state        <= IDLE;
            n_words      <= '0;
            shreg        <= '0;
            idx          <= '0;
            error        <= 1'b0;
            words_loaded <= '0;
            mem_address  <= '0;
            mem_wdata    <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                error        <= 1'b0;
                words_loaded <= '0;
            end
            if (state == HDR0 && acc)
                n_words[15:8] <= rx_data;
            if (state == HDR1 && acc) begin
                n_words[7:0] <= rx_data;
                idx          <= '0;
                if (too_big)
                    error <= 1'b1;
            end
            // the fourth byte goes straight into mem_wdata so WRITE presents a stable word
            if (state == LOAD && acc) begin
                shreg <= {shreg[15:0], rx_data};
                idx   <= idx + 2'd1;
                if (idx == 2'd3) begin
                    mem_wdata   <= {shreg, rx_data};
                    mem_address <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                end
            end
            if (state == WRITE)
                words_loaded <= words_loaded + 16'd1;
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized scoreboard bench for the instruction loader
module tb_instr_loader;
    localparam logic [31:0] BASE = 32'h0040_0000;
    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;
    int checks = 0;
    int fails  = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];
    instr_loader dut (
        .clock(clock), .clear_n(clear_n), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .words_loaded(words_loaded)
    );
    always #5 clock = ~clock;
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction
    // monitor: every write strobe must match the oldest expected write
    always @(negedge clock) begin
        if (clear_n === 1'b1) begin
            if (done === 1'b1)
                done_cnt++;
            if (mem_we === 1'b1) begin
                chk("rx_ready_in_write", 32'(rx_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", mem_address, 32'hxxxx_xxxx);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("mem_address", mem_address, e[63:32]);
                    chk("mem_wdata", mem_wdata, e[31:0]);
                end
            end
        end
    end
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int g;
        if (rnd)
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(negedge clock);
            end
        rx_data  = b;
        rx_valid = 1'b1;
        g = 0;
        while (!rx_ready && g < 100) begin
            @(negedge clock);
            g++;
        end
        if (g >= 100)
            chk("rx_timeout", 32'(g), 32'd0);
        @(negedge clock);
        rx_valid = 1'b0;
    endtask
    task automatic run_session(input logic [31:0] words[$], input bit rnd, input bit hold);
        int n, g, d0;
        logic [31:0] w;
        n  = words.size();
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clock);
        if (!hold)
            start = 1'b0;
        send_byte(8'(n >> 8), rnd);
        send_byte(8'(n), rnd);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            exp_q.push_back({BASE + 32'(4 * i), w});
            for (int b = 3; b >= 0; b--)
                send_byte(w[8*b +: 8], rnd);
        end
        g = 0;
        while (!done && g < 20) begin
            @(negedge clock);
            g++;
        end
        chk("done_latency", 32'(g), n == 0 ? 32'd0 : 32'd1);
        @(negedge clock);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("words_loaded", 32'(words_loaded), 32'(n));
        chk("hold_released", 32'(cpu_hold), 32'd0);
        chk("error_clear", 32'(error), 32'd0);
        chk("writes_pending", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt - d0), 32'd1);
    endtask
    initial begin
        logic [31:0] ws[$];
        clear_n = 1'b0; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        #12;
        chk("rst_ready", 32'(rx_ready), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_address, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        rx_valid = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_no_ready", 32'(rx_ready), 32'd0);
        chk("idle_no_hold", 32'(cpu_hold), 32'd0);
        rx_valid = 1'b0;
        ws = '{32'h0022_0018, 32'h0041_001A};
        run_session(ws, 1'b0, 1'b0);
        run_session(ws, 1'b1, 1'b0);
        // oversized header: sticky error, no writes
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("big_error", 32'(error), 32'd1);
        chk("big_hold", 32'(cpu_hold), 32'd0);
        chk("big_ready", 32'(rx_ready), 32'd0);
        repeat (3) @(negedge clock);
        chk("big_sticky", 32'(error), 32'd1);
        ws = '{};
        run_session(ws, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) begin
            ws = '{};
            repeat ($urandom_range(1, 5)) ws.push_back($urandom);
            run_session(ws, 1'b1, 1'b0);
        end
        ws = '{};
        repeat (256) ws.push_back($urandom);
        run_session(ws, 1'b0, 1'b0);
        // reset mid-word aborts without writing
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        #3;
        clear_n = 1'b0;
        #1;
        chk("abort_ready", 32'(rx_ready), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_hold", 32'(cpu_hold), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_error", 32'(error), 32'd0);
        chk("abort_words", 32'(words_loaded), 32'd0);
        chk("abort_addr", mem_address, 32'd0);
        chk("abort_wdata", mem_wdata, 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h55;
        repeat (3) @(negedge clock);
        chk("post_rst_idle", 32'(cpu_hold), 32'd0);
        rx_valid = 1'b0;
        ws = '{32'hDEAD_BEEF};
        run_session(ws, 1'b1, 1'b0);
        // start held: one session, restart only after passing through IDLE
        ws = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D};
        run_session(ws, 1'b1, 1'b1);
        @(negedge clock);
        chk("restart_hold", 32'(cpu_hold), 32'd1);
        start = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("restart_done", 32'(done), 32'd1);
        repeat (2) @(negedge clock);
        chk("final_idle", 32'(cpu_hold), 32'd0);
        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00400000, byte address of the first instruction word written.
REQ-002 Parameter DEPTH_WORDS, default 256, instruction memory capacity in 32-bit words.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 clear_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a load session; sampled only in IDLE.
REQ-006 rx_data  input  8  program byte stream.
REQ-007 rx_valid  input  1  rx_data holds a valid byte.
REQ-008 rx_ready  output  1  loader accepts a byte; transfer occurs on a rising edge with rx_valid&&rx_ready.
REQ-009 mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-010 mem_address  output  32  byte address of the word being written.
REQ-011 mem_wdata  output  32  assembled instruction word.
REQ-012 cpu_hold  output  1  stalls the processor fetch while a session is in progress.
REQ-013 done  output  1  one-cycle pulse on successful completion.
REQ-014 error  output  1  sticky fault flag, cleared on the next accepted start.
REQ-015 words_loaded  output  16  count of words written in the current or last session.

Function
REQ-016 The FSM SHALL have states IDLE, HDR0, HDR1, LOAD, WRITE and FIN.
REQ-017 IDLE: rx_ready=0, cpu_hold=0; start=1 -> HDR0, clears error and words_loaded.
REQ-018 HDR0/HDR1: rx_ready=1; the accepted bytes form the 16-bit word count N, MSB first (HDR0 = N[15:8]).
REQ-019 On HDR1 accept: N==0 -> FIN; N>DEPTH_WORDS -> IDLE with error=1 and no write; otherwise -> LOAD.
REQ-020 LOAD: rx_ready=1; bytes are assembled big-endian (first byte -> bits 31:24) using a 2-bit byte index.
REQ-021 The 4th byte accept SHALL move to WRITE; WRITE lasts exactly one cycle with mem_we=1 and rx_ready=0.
REQ-022 In WRITE, mem_address SHALL equal BASE_ADDR + 4*words_loaded, with 32-bit wrap-around arithmetic.
REQ-023 mem_address and mem_wdata SHALL be registered and held stable for the whole WRITE cycle, so a falling-edge memory captures them.
REQ-024 words_loaded SHALL increment at the end of WRITE; then words_loaded==N -> FIN, else -> LOAD with byte index 0.
REQ-025 FIN: done=1 for exactly one cycle, then -> IDLE.
REQ-026 cpu_hold SHALL be 1 in HDR0, HDR1, LOAD, WRITE and FIN, and 0 otherwise.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 rx_valid=0 mid-word SHALL stall LOAD without losing the partial word; there is no timeout.
REQ-029 Bytes presented while rx_ready=0 SHALL NOT be consumed.

Reset
REQ-030 clear_n=0 SHALL immediately force IDLE, with rx_ready, mem_we, cpu_hold, done and error =0, words_loaded=0, mem_address=0 and mem_wdata=0.
REQ-031 Reset during LOAD or WRITE SHALL abort the session; a partially assembled word is never written after reset.
REQ-032 After clear_n deasserts, the first state change requires start=1 on a rising edge.

Structure
REQ-033 The state encoding and the default BASE_ADDR and DEPTH_WORDS constants SHALL live in the shared processor package.
REQ-034 The design SHALL be a single module with no sub-module; byte assembly is an inline shift register.

Verification
REQ-035 Scenario 1: start, then bytes 00 02 00 22 00 18 00 41 00 1A -> writes 00220018 @00400000 and 0041001A @00400004, then done pulse, words_loaded=2.
REQ-036 Scenario 2: header 01 01 (N=257) -> error=1, no mem_we, return to IDLE, cpu_hold=0.
REQ-037 Scenario 3: header 00 00 -> done pulse 1 cycle after the 2nd header byte, no write.
REQ-038 Scenario 4: rx_valid toggled randomly during Scenario 1 -> identical writes; rx_ready=0 during each WRITE cycle.
REQ-039 Scenario 5: clear_n pulsed low after 2 bytes of a word -> all outputs 0 asynchronously, no write; a new session then loads correctly from 00400000.
REQ-040 Scenario 6: start held high through an entire session -> exactly one session, done once, then a new session begins only from IDLE.
